// File: rtl/wb_req_master_pkg.sv
// Shared encodings for the Wishbone request master and neighbouring bus bridges.
package wb_req_master_pkg;

  // Width of the completion status field on the response port.
  localparam int WB_STATUS_W = 2;

  // Completion status returned with every response.
  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ERR     = 2'd1,
    ST_RTY     = 2'd2,
    ST_TIMEOUT = 2'd3
  } wb_status_e;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } wb_state_e;

  // Resolve simultaneous terminations: err beats rty, rty beats ack.
  function automatic wb_status_e term_status(input logic err, input logic rty);
    wb_status_e st;
    if (err) begin
      st = ST_ERR;
    end else if (rty) begin
      st = ST_RTY;
    end else begin
      st = ST_OK;
    end
    return st;
  endfunction

endpackage

// File: rtl/wb_req_master_if.sv
// Request, response and Wishbone signal bundle of the request master.
interface wb_req_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // Local controller request port
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic [SEL_WIDTH-1:0]  req_sel_i;

  // Response port
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic [1:0]            rsp_status_o;

  // Wishbone pipelined master side
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;

  // View from the master itself.
  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_data_i, req_sel_i,
    output req_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_status_o,
    input  rsp_ready_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );

  // View from the surroundings (controller plus Wishbone slave).
  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_data_i, req_sel_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_status_o,
    output rsp_ready_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );

endinterface

// File: rtl/wb_req_timeout.sv
// Bus watchdog counter: cleared at transaction start, counts active cycles and
// flags the cycle on which the LIMIT-th active cycle is being spent.
module wb_req_timeout #(
  parameter int LIMIT = 255,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] FULL = CW'(LIMIT);

  logic [CW-1:0] r_count;

  // Count enabled cycles, saturating at LIMIT so the counter cannot wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != FULL)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // The counter holds k-1 during the k-th active cycle.
  assign o_expired = i_en && (r_count >= LAST);

endmodule

// File: rtl/wb_req_master.sv
// Single-outstanding Wishbone pipelined master: one request in, one bus
// cycle out, one response back with read data and completion status.
module wb_req_master
  import wb_req_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_req_master_if.master bus
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  wb_state_e             r_state,        w_state_nxt;
  logic                  r_req_ready,    w_req_ready_nxt;
  logic                  r_rsp_valid,    w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_data,     w_rsp_data_nxt;
  wb_status_e            r_rsp_status,   w_rsp_status_nxt;
  logic                  r_cyc,          w_cyc_nxt;
  logic                  r_stb,          w_stb_nxt;
  logic                  r_we,           w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_adr,          w_adr_nxt;
  logic [SEL_WIDTH-1:0]  r_sel,          w_sel_nxt;
  logic [DATA_WIDTH-1:0] r_dat,          w_dat_nxt;

  logic                  w_term;
  logic                  w_finish;
  wb_status_e            w_fin_status;
  logic [DATA_WIDTH-1:0] w_fin_data;
  logic                  w_tmo_clr;
  logic                  w_tmo_en;
  logic                  w_tmo_expired;

  wb_req_timeout #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expired(w_tmo_expired)
  );

  // Decode the termination outcome; read data survives only a clean ack on a read.
  always_comb begin
    w_term       = bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i;
    w_fin_data   = '0;
    w_fin_status = ST_TIMEOUT;
    if (w_term) begin
      w_fin_status = term_status(bus.wb_err_i, bus.wb_rty_i);
    end else begin
      w_fin_status = ST_TIMEOUT;
    end
    if (bus.wb_ack_i && !bus.wb_err_i && !bus.wb_rty_i && !r_we) begin
      w_fin_data = bus.wb_dat_i;
    end else begin
      w_fin_data = '0;
    end
  end

  // Next-state and next-output logic; a termination outranks the timeout.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_ready_nxt  = 1'b0;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_status_nxt = r_rsp_status;
    w_cyc_nxt        = r_cyc;
    w_stb_nxt        = r_stb;
    w_we_nxt         = r_we;
    w_adr_nxt        = r_adr;
    w_sel_nxt        = r_sel;
    w_dat_nxt        = r_dat;
    w_tmo_clr        = 1'b0;
    w_tmo_en         = 1'b0;
    w_finish         = 1'b0;

    case (r_state)
      S_IDLE: begin
        // r_req_ready is low for the first cycle after reset release.
        if (bus.req_valid_i && r_req_ready) begin
          w_we_nxt    = bus.req_we_i;
          w_adr_nxt   = bus.req_addr_i;
          w_sel_nxt   = bus.req_sel_i;
          w_dat_nxt   = bus.req_data_i;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b1;
          w_tmo_clr   = 1'b1;
          w_state_nxt = S_STROBE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STROBE: begin
        w_tmo_en = 1'b1;
        if (w_term || w_tmo_expired) begin
          w_finish = 1'b1;
        end else if (!bus.wb_stall_i) begin
          w_stb_nxt   = 1'b0;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_STROBE;
        end
      end
      S_WAIT: begin
        w_tmo_en = 1'b1;
        if (w_term || w_tmo_expired) begin
          w_finish = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_cyc_nxt       = 1'b0;
        w_stb_nxt       = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase

    if (w_finish) begin
      w_cyc_nxt        = 1'b0;
      w_stb_nxt        = 1'b0;
      w_rsp_valid_nxt  = 1'b1;
      w_rsp_data_nxt   = w_fin_data;
      w_rsp_status_nxt = w_fin_status;
      w_state_nxt      = S_RESP;
      w_req_ready_nxt  = 1'b0;
    end else begin
      w_req_ready_nxt = (w_state_nxt == S_IDLE);
    end
  end

  // State and output registers; reset abandons any bus cycle immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= ST_OK;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_sel        <= '0;
      r_dat        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_status <= w_rsp_status_nxt;
      r_cyc        <= w_cyc_nxt;
      r_stb        <= w_stb_nxt;
      r_we         <= w_we_nxt;
      r_adr        <= w_adr_nxt;
      r_sel        <= w_sel_nxt;
      r_dat        <= w_dat_nxt;
    end
  end

  assign bus.req_ready_o  = r_req_ready;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_data_o   = r_rsp_data;
  assign bus.rsp_status_o = r_rsp_status;
  assign bus.wb_cyc_o     = r_cyc;
  assign bus.wb_stb_o     = r_stb;
  assign bus.wb_we_o      = r_we;
  assign bus.wb_adr_o     = r_adr;
  assign bus.wb_sel_o     = r_sel;
  assign bus.wb_dat_o     = r_dat;

endmodule
